lsu_mem_responder: RTL and testbench
====================================

Name: lsu_mem_responder

Overview:
- Memory-side responder for the LSU data-memory port: accepts the read and write requests the load/store unit issues and returns read data after a fixed latency.
- Holds a word-addressed backing RAM (8-byte words).
- Used as the data memory in core-level simulation and in the LSU benches.
- The port has no backpressure, so the block accepts one read and one write every cycle.

Parameters:
- ADDR_BITS, 10: word-index width; the RAM holds 2**ADDR_BITS 64-bit words.
- READ_LATENCY, 2: cycles from read accept to mem_rvalid (legal range 1..8).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- mem_ren  input  1  read request; accepted in any cycle where it is high.
- mem_raddr  input  64  read byte address.
- mem_wen  input  1  write request; accepted in any cycle where it is high.
- mem_waddr  input  64  write byte address.
- mem_wdata  input  64  write data, full 64-bit word.
- mem_rvalid  output  1  read data valid; one-cycle pulse per accepted read.
- mem_rdata  output  64  read data; qualified by mem_rvalid.
- init_done  output  1  high once the post-reset RAM clear completes.

Behaviour:
- Reset (rst low, async): mem_rvalid=0, mem_rdata=0, init_done=0, read pipeline valid bits cleared, clear counter=0, FSM=CLEAR. RAM contents are not reset directly.
- Reset asserted mid-operation: in-flight reads are discarded with no mem_rvalid. The clear restarts from word 0 after release.
- Word index is addr[ADDR_BITS+2:3]. addr[2:0] is ignored; every access is a whole aligned word.
- FSM CLEAR:
  - Writes 0 to word[clear_cnt] each cycle and increments clear_cnt.
  - After writing word 2**ADDR_BITS-1 → READY. CLEAR lasts exactly 2**ADDR_BITS cycles after reset release.
  - init_done rises on the first READY cycle.
- FSM READY: terminal; left only by reset.
- Requests in CLEAR: mem_wen is dropped. mem_ren is still accepted and returns 0 with normal latency and a normal mem_rvalid pulse.
- Write in READY: RAM[widx(mem_waddr)] <= mem_wdata at the accepting edge.
- Read data sampling:
  - Data is sampled in the accept cycle and carried through a READ_LATENCY-deep valid/data shift pipeline.
  - A write to the same word in the same cycle is forwarded: the read returns mem_wdata (write-before-read).
  - Writes in later cycles do not affect reads already in flight.
- Latency: a read accepted on edge N produces mem_rvalid=1 and mem_rdata valid for exactly the one cycle following edge N+READ_LATENCY-1. With READ_LATENCY=1 this is the cycle after accept.
- Throughput: back-to-back reads every cycle produce back-to-back mem_rvalid pulses, in request order.
- mem_rdata is 0 whenever mem_rvalid is 0.
- Simultaneous read and write to different words: both are serviced independently.
- Two writes to one word on consecutive cycles: the last write wins.

Optional Feature:
- Macro: LSU_MEM_RANGE_CHECK_EN.
- When defined:
  - Any access with address bits [63:ADDR_BITS+3] nonzero is out of range.
  - An out-of-range read returns 0 (mem_rvalid still pulses at the normal latency).
  - An out-of-range write is dropped.
  - Extra output port mem_err (1 bit) is set sticky on the edge after the offending access and cleared only by reset.
- When not defined: upper address bits are ignored (addresses alias modulo 2**(ADDR_BITS+3)), and there is no mem_err port.

Test Plan:
- Reset clear: release rst with ADDR_BITS=4 → init_done rises exactly 16 cycles later. A read of 0x40 in READY returns 0.
- Write then read: write 0x0000_0000_DEAD_BEEF to 0x18, then the next cycle read 0x1C (same word, misaligned low bits) → mem_rvalid exactly READ_LATENCY cycles later with rdata=0xDEADBEEF.
- Forwarding: in one cycle write 0x1234 to 0x20 and read 0x20 → returns 0x1234.
  - Then write 0x5678 to 0x20 while that read is in flight; the in-flight read still returns 0x1234.
- Streaming: preload words 0..7 with values 100..107, issue 8 consecutive-cycle reads → 8 consecutive mem_rvalid pulses returning 100..107 in order. mem_rdata=0 before and after the burst.
- Reset mid-flight: issue reads on 2 cycles, assert rst before they return → no mem_rvalid appears, and the FSM re-enters CLEAR (init_done=0).
- With LSU_MEM_RANGE_CHECK_EN: read 0x1_0000_0000 with ADDR_BITS=10 → rdata=0, mem_err=1 and stays 1. A write to the same address leaves word 0 unchanged.

Source files
------------

// File: rtl/lsu_mem_responder.sv
// lsu_mem_responder: memory-side responder for the LSU data-memory port.
// It holds a word-addressed RAM of 64-bit words. Reads return data after a
// fixed latency. The port has no backpressure: one read and one write are
// accepted every cycle. After reset the RAM is cleared one word per cycle,
// and init_done goes high when the clear has finished.
//
// Optional feature: define LSU_MEM_RANGE_CHECK_EN to enable address range
// checking. An access with any address bit above the RAM span set is then
// out of range: a read returns 0 and a write is dropped. The sticky mem_err
// port reports that such an access happened.
module lsu_mem_responder #(
    parameter int ADDR_BITS    = 10, // word-index width
    parameter int READ_LATENCY = 2   // accept-to-rvalid cycles, 1..8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_ren,
    input  logic [63:0] mem_raddr,
    input  logic        mem_wen,
    input  logic [63:0] mem_waddr,
    input  logic [63:0] mem_wdata,
    output logic        mem_rvalid,
    output logic [63:0] mem_rdata,
    output logic        init_done
`ifdef LSU_MEM_RANGE_CHECK_EN
    ,
    output logic        mem_err
`endif
);

    localparam int DEPTH = 1 << ADDR_BITS;

    typedef enum logic {
        ST_CLEAR,
        ST_READY
    } state_t;

    state_t                 state;
    logic [ADDR_BITS-1:0]   clear_cnt;
    logic [63:0]            mem [DEPTH];

    logic [ADDR_BITS-1:0]   ridx;
    logic [ADDR_BITS-1:0]   widx;
    logic                   rd_oor;
    logic                   wr_oor;
    logic                   wr_en_eff;
    logic [63:0]            rd_sample;

    logic [READ_LATENCY-1:0] pipe_v;
    logic [63:0]             pipe_d [READ_LATENCY];

    // Word index: the low three bits select a byte inside the word and are ignored.
    assign ridx = mem_raddr[ADDR_BITS+2:3];
    assign widx = mem_waddr[ADDR_BITS+2:3];

`ifdef LSU_MEM_RANGE_CHECK_EN
    assign rd_oor = |mem_raddr[63:ADDR_BITS+3];
    assign wr_oor = |mem_waddr[63:ADDR_BITS+3];

    logic unused_addr_bits;
    assign unused_addr_bits = ^{mem_raddr[2:0], mem_waddr[2:0]};
`else
    // Upper address bits alias. They are collected here only so that they
    // are visibly consumed.
    assign rd_oor = 1'b0;
    assign wr_oor = 1'b0;

    logic unused_addr_bits;
    assign unused_addr_bits = ^{mem_raddr[2:0], mem_waddr[2:0],
                                mem_raddr[63:ADDR_BITS+3], mem_waddr[63:ADDR_BITS+3]};
`endif

    // Writes take effect only once the clear has finished and the address is in range.
    assign wr_en_eff = (state == ST_READY) && mem_wen && !wr_oor;

    // Read sample for this cycle. A write to the same word in the same cycle is forwarded.
    always_comb begin
        // NOTE: give every always_comb output a default first so that no path can infer a latch.
        rd_sample = '0;
        if ((state == ST_READY) && !rd_oor) begin
            if (wr_en_eff && (widx == ridx)) begin
                rd_sample = mem_wdata;
            end else begin
                rd_sample = mem[ridx];
            end
        end
    end

    // FSM: walk clear_cnt through every word, then stay in READY until reset.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
        if (!rst) begin
            state     <= ST_CLEAR;
            clear_cnt <= '0;
            init_done <= 1'b0;
        end else begin
            case (state)
                ST_CLEAR: begin
                    clear_cnt <= clear_cnt + 1'b1;
                    if (clear_cnt == '1) begin
                        state     <= ST_READY;
                        init_done <= 1'b1;
                    end
                end
                ST_READY: begin
                    state <= ST_READY;
                end
                default: begin
                    state <= ST_CLEAR;
                end
            endcase
        end
    end

    // RAM write port: the clear sweep while in CLEAR, LSU writes once READY.
    always_ff @(posedge clk) begin
        // NOTE: the RAM array has no reset branch. It is cleared by the FSM sweep, which keeps it mappable to RAM macros.
        if (state == ST_CLEAR) begin
            mem[clear_cnt] <= '0;
        end else if (wr_en_eff) begin
            mem[widx] <= mem_wdata;
        end
    end

    // Read pipeline: valid/data shift chain. Data is zero whenever valid is zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pipe_v <= '0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                pipe_d[i] <= '0;
            end
        end else begin
            pipe_v[0] <= mem_ren;
            pipe_d[0] <= mem_ren ? rd_sample : 64'd0;
            for (int i = 1; i < READ_LATENCY; i++) begin
                pipe_v[i] <= pipe_v[i-1];
                pipe_d[i] <= pipe_d[i-1];
            end
        end
    end

    assign mem_rvalid = pipe_v[READ_LATENCY-1];
    assign mem_rdata  = pipe_d[READ_LATENCY-1];

`ifdef LSU_MEM_RANGE_CHECK_EN
    // Sticky error flag: set by any out-of-range request, cleared only by reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_err <= 1'b0;
        end else if ((mem_ren && rd_oor) || (mem_wen && wr_oor)) begin
            mem_err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_lsu_mem_responder.sv
// Directed bench for lsu_mem_responder with ADDR_BITS=4 and READ_LATENCY=2.
// Inputs are driven and outputs are sampled on the falling clock edge.
module tb_lsu_mem_responder;

    localparam int AB = 4;
    localparam int RL = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_ren;
    logic [63:0] mem_raddr;
    logic        mem_wen;
    logic [63:0] mem_waddr;
    logic [63:0] mem_wdata;
    logic        mem_rvalid;
    logic [63:0] mem_rdata;
    logic        init_done;
`ifdef LSU_MEM_RANGE_CHECK_EN
    logic        mem_err;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int ticks    = 0;
    int t0;

    always #5 clk = ~clk;

    lsu_mem_responder #(
        .ADDR_BITS    (AB),
        .READ_LATENCY (RL)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .mem_ren    (mem_ren),
        .mem_raddr  (mem_raddr),
        .mem_wen    (mem_wen),
        .mem_waddr  (mem_waddr),
        .mem_wdata  (mem_wdata),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .init_done  (init_done)
`ifdef LSU_MEM_RANGE_CHECK_EN
        ,
        .mem_err    (mem_err)
`endif
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        ticks++;
    endtask

    task automatic write_word(input logic [63:0] addr, input logic [63:0] data);
        mem_wen   = 1'b1;
        mem_waddr = addr;
        mem_wdata = data;
        tick();
        mem_wen   = 1'b0;
    endtask

    // Issue one read and check that rvalid arrives exactly RL cycles later, as a single pulse.
    task automatic read_check(input logic [63:0] addr, input logic [63:0] exp, input string tag);
        mem_ren   = 1'b1;
        mem_raddr = addr;
        for (int i = 0; i < RL; i++) begin
            tick();
            if (i == 0) mem_ren = 1'b0;
            if (i < RL - 1) check({tag, "_early"}, {63'd0, mem_rvalid}, 64'd0);
        end
        check({tag, "_vld"},  {63'd0, mem_rvalid}, 64'd1);
        check({tag, "_data"}, mem_rdata, exp);
        tick();
        check({tag, "_post"}, {63'd0, mem_rvalid}, 64'd0);
    endtask

    // Wait a bounded number of cycles for init_done, then check the exact cycle count.
    task automatic wait_init(input int start, input string tag);
        while (!init_done && (ticks - start) < 64) tick();
        check(tag, 64'(ticks - start), 64'd16);
    endtask

    initial begin
        rst       = 1'b0;
        mem_ren   = 1'b0;
        mem_raddr = '0;
        mem_wen   = 1'b0;
        mem_waddr = '0;
        mem_wdata = '0;
        tick();
        tick();
        check("rst_init_done", {63'd0, init_done}, 64'd0);
        check("rst_rvalid",    {63'd0, mem_rvalid}, 64'd0);
        check("rst_rdata",     mem_rdata, 64'd0);

        // Clear sweep: init_done rises exactly 16 cycles after release.
        rst = 1'b1;
        t0  = ticks;
        wait_init(t0, "clear_len");
        check("init_done_hi", {63'd0, init_done}, 64'd1);
        read_check(64'h40, 64'd0, "ready_rd40");

        // Write, then read the same word through a misaligned address.
        write_word(64'h18, 64'h0000_0000_DEAD_BEEF);
        read_check(64'h1C, 64'h0000_0000_DEAD_BEEF, "wr_rd_1c");

        // Same-cycle forwarding; a later write must not disturb the read in flight.
        mem_wen = 1'b1; mem_waddr = 64'h20; mem_wdata = 64'h1234;
        mem_ren = 1'b1; mem_raddr = 64'h20;
        tick();
        mem_ren = 1'b0; mem_wdata = 64'h5678;
        tick();
        mem_wen = 1'b0;
        check("fwd_vld",  {63'd0, mem_rvalid}, 64'd1);
        check("fwd_data", mem_rdata, 64'h1234);
        tick();
        read_check(64'h20, 64'h5678, "last_wr_wins");

        // Streaming: preload words 0..7, then read them back-to-back.
        for (int i = 0; i < 8; i++) write_word(64'(i * 8), 64'(100 + i));
        for (int k = 0; k <= 8 + RL; k++) begin
            if (k >= RL && k - RL < 8) begin
                check($sformatf("strm_vld%0d", k),  {63'd0, mem_rvalid}, 64'd1);
                check($sformatf("strm_data%0d", k), mem_rdata, 64'(100 + k - RL));
            end else begin
                check($sformatf("strm_idle_vld%0d", k),  {63'd0, mem_rvalid}, 64'd0);
                check($sformatf("strm_idle_data%0d", k), mem_rdata, 64'd0);
            end
            mem_ren   = (k < 8);
            mem_raddr = 64'(k * 8);
            tick();
        end
        mem_ren = 1'b0;

        // Reset while two reads are in flight: no rvalid may appear.
        mem_ren = 1'b1; mem_raddr = 64'h40;
        tick();
        mem_raddr = 64'h48;
        #2 rst = 1'b0;
        mem_ren = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("midrst_vld%0d", i), {63'd0, mem_rvalid}, 64'd0);
            check($sformatf("midrst_init%0d", i), {63'd0, init_done}, 64'd0);
        end
        rst = 1'b1;
        t0  = ticks;
        // A read during CLEAR returns 0 with a normal pulse, even though the word held 103.
        read_check(64'h18, 64'd0, "clear_rd");
        check("clear_init_lo", {63'd0, init_done}, 64'd0);
        wait_init(t0, "reclear_len");
        read_check(64'h8, 64'd0, "reclear_w1");

        // Out-of-range or aliased access to 0x1_0000_0000.
        write_word(64'h0, 64'h77);
`ifdef LSU_MEM_RANGE_CHECK_EN
        check("err_lo", {63'd0, mem_err}, 64'd0);
        read_check(64'h1_0000_0000, 64'd0, "oor_rd");
        check("err_set", {63'd0, mem_err}, 64'd1);
        write_word(64'h1_0000_0000, 64'hAAAA);
        read_check(64'h0, 64'h77, "oor_wr_drop");
        check("err_sticky", {63'd0, mem_err}, 64'd1);
`else
        write_word(64'h1_0000_0000, 64'hAAAA);
        read_check(64'h0, 64'hAAAA, "alias_wr");
        read_check(64'h1_0000_0008, 64'd0, "alias_rd_w1");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
